mux_4x1_rr_arbiter: RTL
=======================

Name: mux_4x1_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4x1 n-bit multiplexer datapath among four requesters (A, B, C, D) and drives one downstream sink.
- Registers the grant and mux select, and forwards the granted requester's data with a valid/ready handshake.
- Enforces a per-grant burst limit so that no requester starves the others.

Parameters:
- n, 4, data width of each requester bus and of Y
- BURST, 4, maximum transfers per grant before rotation; legal range 1..255

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst_n  input  1  asynchronous active-low reset
- REQ  input  4  request per requester; bit0=A, bit1=B, bit2=C, bit3=D
- A  input  n  requester 0 data
- B  input  n  requester 1 data
- C  input  n  requester 2 data
- D  input  n  requester 3 data
- READY  input  1  sink ready to accept Y this cycle
- GNT  output  4  registered one-hot grant; all zero when idle
- S  output  2  registered mux select (index of the granted requester)
- Y  output  n  selected data when VALID=1, otherwise all zero
- VALID  output  1  Y holds a transfer offer

Behaviour:
- Reset (rst_n=0, takes effect immediately regardless of clk):
  - GNT=4'b0000, S=2'b00, VALID=0, Y=0.
  - State=IDLE, burst count CNT=0, last-served pointer LAST=2'd3, so A has first priority after reset.
- Priority: search order starts at LAST+1 and wraps mod 4. The first index with REQ set wins.
- IDLE state:
  - VALID=0.
  - If any REQ bit is 1 at a rising edge, the next state is BUSY; GNT becomes one-hot at the winner, S becomes the winner index, CNT becomes 0.
  - Latency from REQ to GNT is 1 cycle.
- BUSY state:
  - VALID = REQ[S].
  - Y = mux(A,B,C,D by S), combinational from the current data inputs, gated by VALID.
  - A transfer occurs on any edge where VALID & READY = 1.
  - On a transfer with CNT<BURST-1: CNT increments and the grant holds.
  - Release condition is either (a) a transfer with CNT==BURST-1, or (b) REQ[S]==0 at the edge (requester withdrew; no transfer occurs).
  - On release: LAST<=S and CNT<=0.
    - If any other REQ bit (excluding S) is set, re-arbitrate from the new LAST and grant directly in the next cycle with no idle bubble.
    - Otherwise, if REQ[S] is still set, re-grant S.
    - Otherwise, go to IDLE with GNT=0.
- Boundary conditions:
  - BURST=1: rotate after every transfer.
  - READY held low: grant, S and Y remain stable; CNT does not advance; no timeout.
  - Simultaneous release and new requests: the new REQ bits are sampled at the same edge and take part in arbitration.
  - All four requesting continuously: grant order is A,B,C,D,A,... with BURST transfers each.
  - Data changing while granted is passed through combinationally; the sink samples Y on the transfer edge.
  - Reset asserted mid-burst: the grant drops asynchronously and the partial burst is discarded; after reset, priority restarts at A.
- Invariants: GNT is always zero or one-hot, GNT[S]=1 whenever GNT!=0, and VALID is never 1 in IDLE.

Optional Feature:
- Macro: MUX_ARB_LOCK_EN.
- When defined:
  - Adds input LOCK (1 bit).
  - In BUSY, while LOCK=1 the burst-limit release (a) is suppressed; CNT saturates at BURST-1 and the grant holds until LOCK=0 at a transfer edge or REQ[S] drops.
  - LOCK is ignored in IDLE.
- When undefined: the LOCK port does not exist and behaviour is exactly as above.

Test Plan:
- Reset release, REQ=0001, A=4'b1010, READY=1, BURST=4:
  - GNT=0001 and S=0 on the first edge.
  - VALID=1 and Y=4'b1010 for 4 transfers; then the block re-grants A, because A is the only requester.
- REQ=1111, A=1010, B=0110, C=1101, D=0001, READY=1, BURST=1:
  - Y sequence 1010, 0110, 1101, 0001, 1010 on consecutive cycles.
  - No idle bubble; GNT rotates 0001→0010→0100→1000.
- Granted B with READY=0 for 5 cycles:
  - GNT=0010, S=1 and Y=0110 stay stable; CNT stays 0.
  - After READY=1, exactly BURST transfers occur before rotation.
- Granted C, REQ[2] drops mid-burst while REQ[3]=1:
  - VALID=0 that cycle; the next cycle GNT=1000, Y=4'b0001, CNT=0.
- rst_n pulsed low mid-burst while granted D:
  - GNT=0, VALID=0 and Y=0 immediately, without waiting for a clock edge.
  - After release with REQ=1111, A is granted first.
- With MUX_ARB_LOCK_EN defined, LOCK=1, REQ=0011, BURST=2:
  - A holds the grant for 6 transfers; LOCK→0 at a transfer edge, then the next edge grants B.

Source files
------------

// File: rtl/mux_4x1_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 n-bit mux among requesters A..D, with a per-grant burst limit (optional LOCK via MUX_ARB_LOCK_EN).
// Latency: GNT/S registered, 1 cycle after REQ; Y/VALID combinational from the current grant, REQ and data.
// Backpressure: READY low holds grant, select and burst count; rotation happens only on transfers or withdrawal.
module mux_4x1_rr_arbiter #(
    parameter int n     = 4,
    parameter int BURST = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   REQ,
    input  logic [n-1:0] A,
    input  logic [n-1:0] B,
    input  logic [n-1:0] C,
    input  logic [n-1:0] D,
    input  logic         READY,
`ifdef MUX_ARB_LOCK_EN
    input  logic         LOCK,
`endif
    output logic [3:0]   GNT,
    output logic [1:0]   S,
    output logic [n-1:0] Y,
    output logic         VALID
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [7:0] CNT_MAX = 8'(BURST - 1);

    state_t       state;
    logic [7:0]   cnt;
    logic [1:0]   last;
    logic [n-1:0] sel_dat;
    logic [1:0]   pick_from;
    logic [1:0]   win;
    logic         xfer;
    logic         at_limit;
    logic         lock_hold;
    logic         rel;

    // First set bit searching from (from+1) and wrapping; 'from' itself is checked last.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] from);
        logic [1:0] idx;
        logic [1:0] res;
        res = from;
        for (int k = 4; k >= 1; k--) begin
            idx = from + 2'(k);
            if (req[idx]) res = idx;
        end
        return res;
    endfunction

`ifdef MUX_ARB_LOCK_EN
    assign lock_hold = LOCK;
`else
    assign lock_hold = 1'b0;
`endif

    always_comb begin
        sel_dat = A;
        case (S)
            2'd0: sel_dat = A;
            2'd1: sel_dat = B;
            2'd2: sel_dat = C;
            2'd3: sel_dat = D;
            default: sel_dat = A;
        endcase
    end

    assign VALID     = (state == BUSY) && REQ[S];
    assign Y         = VALID ? sel_dat : '0;
    assign xfer      = VALID && READY;
    assign at_limit  = (cnt == CNT_MAX);
    // Withdrawal releases immediately; the burst limit releases only on the final transfer.
    assign rel       = (state == BUSY) && (!REQ[S] || (xfer && at_limit && !lock_hold));
    // On release the old grant is searched last, so it is re-granted only if alone.
    assign pick_from = (state == BUSY) ? S : last;
    assign win       = rr_pick(REQ, pick_from);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 8'd0;
            last  <= 2'd3;
            GNT   <= 4'b0000;
            S     <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (|REQ) begin
                        state <= BUSY;
                        S     <= win;
                        GNT   <= 4'b0001 << win;
                        cnt   <= 8'd0;
                    end
                end
                BUSY: begin
                    if (rel) begin
                        last <= S;
                        cnt  <= 8'd0;
                        if (|REQ) begin
                            S   <= win;
                            GNT <= 4'b0001 << win;
                        end else begin
                            state <= IDLE;
                            GNT   <= 4'b0000;
                        end
                    end else if (xfer && !at_limit) begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    GNT   <= 4'b0000;
                end
            endcase
        end
    end

endmodule
